// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S-array geometry, byte type, default message geometry
// and the keystream engine state encoding.
package rc4_pkg;

   localparam int S_DEPTH     = 256;
   localparam int DEF_MSG_LEN = 32;
   localparam int DEF_MSG_AW  = 5;

   typedef logic [7:0] rc4_byte_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_INC_I,
      ST_WAIT_SI,
      ST_LATCH_SI,
      ST_ADDR_SJ,
      ST_WAIT_SJ,
      ST_LATCH_SJ,
      ST_WR_SI,
      ST_WR_SJ,
      ST_ADDR_F,
      ST_WAIT_F,
      ST_LATCH_F,
      ST_WR_RAM,
      ST_NEXT,
      ST_DONE
   } prga_state_t;

endpackage

// File: rtl/prga_decrypt.sv
// RC4 keystream engine: swaps S[i]/S[j], XORs S[S[i]+S[j]] into each ROM byte.
// 13 cycles per byte; start is ignored outside IDLE; outputs are all registered.
module prga_decrypt
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = DEF_MSG_LEN,
   parameter int MSG_AW  = DEF_MSG_AW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [7:0]        s_addr,
   output logic [7:0]        s_wdata,
   output logic              s_wren,
   input  logic [7:0]        s_rdata,
   output logic [MSG_AW-1:0] rom_addr,
   input  logic [7:0]        rom_rdata,
   output logic [MSG_AW-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_wren,
   output logic              finished
);

   localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

   prga_state_t       state;
   prga_state_t       state_nxt;
   rc4_byte_t         i;
   rc4_byte_t         j;
   rc4_byte_t         si;
   rc4_byte_t         sj;
   rc4_byte_t         f;
   rc4_byte_t         enc;
   logic [MSG_AW-1:0] k;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (start) state_nxt = ST_INIT;
         ST_INIT:     state_nxt = ST_INC_I;
         ST_INC_I:    state_nxt = ST_WAIT_SI;
         ST_WAIT_SI:  state_nxt = ST_LATCH_SI;
         ST_LATCH_SI: state_nxt = ST_ADDR_SJ;
         ST_ADDR_SJ:  state_nxt = ST_WAIT_SJ;
         ST_WAIT_SJ:  state_nxt = ST_LATCH_SJ;
         ST_LATCH_SJ: state_nxt = ST_WR_SI;
         ST_WR_SI:    state_nxt = ST_WR_SJ;
         ST_WR_SJ:    state_nxt = ST_ADDR_F;
         ST_ADDR_F:   state_nxt = ST_WAIT_F;
         ST_WAIT_F:   state_nxt = ST_LATCH_F;
         ST_LATCH_F:  state_nxt = ST_WR_RAM;
         ST_WR_RAM:   state_nxt = ST_NEXT;
         ST_NEXT:     state_nxt = (k == K_LAST) ? ST_DONE : ST_INC_I;
         ST_DONE:     state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Registers are loaded on entry to a state, so each state's outputs are
   // visible during that state and the 1-cycle memories are read in the WAIT states.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i         <= '0;
         j         <= '0;
         k         <= '0;
         si        <= '0;
         sj        <= '0;
         f         <= '0;
         enc       <= '0;
         s_addr    <= '0;
         s_wdata   <= '0;
         s_wren    <= 1'b0;
         rom_addr  <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_wren  <= 1'b0;
         finished  <= 1'b0;
      end else begin
         s_wren   <= 1'b0;
         ram_wren <= 1'b0;
         finished <= 1'b0;
         case (state_nxt)
            ST_INIT: begin
               i <= '0;
               j <= '0;
               k <= '0;
            end
            ST_INC_I: begin
               i      <= i + 8'd1;
               s_addr <= i + 8'd1;
               if (state == ST_NEXT) k <= k + 1'b1;
            end
            ST_LATCH_SI: begin
               si <= s_rdata;
               j  <= j + s_rdata;
            end
            ST_ADDR_SJ:  s_addr <= j;
            ST_LATCH_SJ: sj <= s_rdata;
            ST_WR_SI: begin
               s_addr  <= i;
               s_wdata <= sj;
               s_wren  <= 1'b1;
            end
            // When i==j this rewrites the same location with si, which equals sj.
            ST_WR_SJ: begin
               s_addr  <= j;
               s_wdata <= si;
               s_wren  <= 1'b1;
            end
            ST_ADDR_F: begin
               s_addr   <= si + sj;
               rom_addr <= k;
            end
            ST_LATCH_F: begin
               f   <= s_rdata;
               enc <= rom_rdata;
            end
            ST_WR_RAM: begin
               ram_addr  <= k;
               ram_wdata <= f ^ enc;
               ram_wren  <= 1'b1;
            end
            ST_DONE: finished <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: hand-computed identity-S vectors, a software RC4
// golden model, ignored start pulses, mid-run reset and a 256-byte instance.
module tb_prga_decrypt;
   import rc4_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       start0, start1;
   logic [7:0] s_addr0, s_wdata0, s_rdata0, rom_rdata0, ram_wdata0;
   logic [4:0] rom_addr0, ram_addr0;
   logic       s_wren0, ram_wren0, fin0;
   logic [7:0] s_addr1, s_wdata1, s_rdata1, rom_rdata1, ram_wdata1;
   logic [7:0] rom_addr1, ram_addr1;
   logic       s_wren1, ram_wren1, fin1;

   prga_decrypt #(.MSG_LEN(32), .MSG_AW(5)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0),
      .s_addr(s_addr0), .s_wdata(s_wdata0), .s_wren(s_wren0), .s_rdata(s_rdata0),
      .rom_addr(rom_addr0), .rom_rdata(rom_rdata0),
      .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_wren(ram_wren0),
      .finished(fin0));

   prga_decrypt #(.MSG_LEN(256), .MSG_AW(8)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1),
      .s_addr(s_addr1), .s_wdata(s_wdata1), .s_wren(s_wren1), .s_rdata(s_rdata1),
      .rom_addr(rom_addr1), .rom_rdata(rom_rdata1),
      .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_wren(ram_wren1),
      .finished(fin1));

   logic [7:0] rom   [256];
   logic [7:0] sinit [256];
   logic [7:0] smem0 [256];
   logic [7:0] smem1 [256];
   logic [7:0] ram0  [32];
   logic [7:0] ram1  [256];
   int         wcnt0 [32];
   int         wcnt1 [256];
   logic [7:0] ms    [256];
   logic [7:0] expk  [256];
   logic       load0, load1;
   int         cyc = 0;
   int         fcnt0, fcnt1, fcyc0, fcyc1, swn0;
   logic [7:0] sw_a0, sw_d0, sw_a1, sw_d1, snap_s1, snap_s2, snap_s3;
   int         checks = 0;
   int         failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // S memory, ROM and RAM models for the 32-byte instance
   always @(posedge clk) begin
      if (load0) begin
         for (int x = 0; x < 256; x++) smem0[x] <= sinit[x];
         for (int x = 0; x < 32; x++) wcnt0[x] <= 0;
         fcnt0 <= 0;
         swn0  <= 0;
      end else begin
         if (s_wren0) begin
            smem0[s_addr0] <= s_wdata0;
            if (swn0 == 0) begin sw_a0 <= s_addr0; sw_d0 <= s_wdata0; end
            if (swn0 == 1) begin sw_a1 <= s_addr0; sw_d1 <= s_wdata0; end
            swn0 <= swn0 + 1;
         end
         if (ram_wren0) begin
            ram0[ram_addr0]  <= ram_wdata0;
            wcnt0[ram_addr0] <= wcnt0[ram_addr0] + 1;
            if (ram_addr0 == 5'd0) snap_s1 <= smem0[1];
            if (ram_addr0 == 5'd1) begin snap_s2 <= smem0[2]; snap_s3 <= smem0[3]; end
         end
         if (fin0) begin fcnt0 <= fcnt0 + 1; fcyc0 <= cyc; end
      end
      s_rdata0   <= smem0[s_addr0];
      rom_rdata0 <= rom[rom_addr0];
   end

   always @(posedge clk) begin
      if (load1) begin
         for (int x = 0; x < 256; x++) begin smem1[x] <= sinit[x]; wcnt1[x] <= 0; end
         fcnt1 <= 0;
      end else begin
         if (s_wren1) smem1[s_addr1] <= s_wdata1;
         if (ram_wren1) begin
            ram1[ram_addr1]  <= ram_wdata1;
            wcnt1[ram_addr1] <= wcnt1[ram_addr1] + 1;
         end
         if (fin1) begin fcnt1 <= fcnt1 + 1; fcyc1 <= cyc; end
      end
      s_rdata1   <= smem1[s_addr1];
      rom_rdata1 <= rom[rom_addr1];
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic ksa();
      logic [7:0] kb [3];
      logic [7:0] t;
      int         kj;
      kb[0] = 8'h00; kb[1] = 8'h02; kb[2] = 8'h49;
      for (int x = 0; x < 256; x++) sinit[x] = 8'(x);
      kj = 0;
      for (int x = 0; x < 256; x++) begin
         kj = (kj + int'(sinit[x]) + int'(kb[x % 3])) % 256;
         t = sinit[x]; sinit[x] = sinit[kj]; sinit[kj] = t;
      end
   endtask

   // Software RC4 PRGA over ms[], starting from sinit[]
   task automatic model(input int n);
      int         mi, mj;
      logic [7:0] a, b, t;
      for (int x = 0; x < 256; x++) ms[x] = sinit[x];
      mi = 0; mj = 0;
      for (int kk = 0; kk < n; kk++) begin
         mi = (mi + 1) % 256;
         mj = (mj + int'(ms[mi])) % 256;
         a = ms[mi]; b = ms[mj];
         ms[mi] = b; ms[mj] = a;
         t = a + b;
         expk[kk] = ms[t] ^ rom[kk];
      end
   endtask

   task automatic load(input int which);
      @(negedge clk);
      if (which == 0) load0 = 1'b1; else load1 = 1'b1;
      @(negedge clk);
      load0 = 1'b0; load1 = 1'b0;
   endtask

   task automatic run(input int which, input int n, input int pa, input int pb, output int lat);
      int t0;
      bit done;
      @(negedge clk);
      if (which == 0) start0 = 1'b1; else start1 = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      done = 0;
      for (int c = 1; c < 13 * n + 60 && !done; c++) begin
         @(negedge clk);
         if (which == 0) start0 = (c == pa || c == pb);
         if ((which == 0 ? fcnt0 : fcnt1) != 0) done = 1;
      end
      start0 = 1'b0;
      chk("finished_seen", int'(done), 1);
      lat = (which == 0 ? fcyc0 : fcyc1) - t0;
      repeat (20) @(negedge clk);
   endtask

   task automatic compare0(input string tag);
      int bad_ram, bad_s, bad_w;
      bad_ram = 0; bad_s = 0; bad_w = 0;
      for (int x = 0; x < 32; x++) begin
         if (ram0[x] !== expk[x]) bad_ram++;
         if (wcnt0[x] != 1) bad_w++;
      end
      for (int x = 0; x < 256; x++) if (smem0[x] !== ms[x]) bad_s++;
      chk({tag, "_ram_mismatches"}, bad_ram, 0);
      chk({tag, "_s_mismatches"}, bad_s, 0);
      chk({tag, "_ram_write_counts"}, bad_w, 0);
      chk({tag, "_finished_count"}, fcnt0, 1);
   endtask

   typedef struct {
      logic [7:0] enc;
      logic [7:0] plain;
   } vec_t;

   vec_t tbl [6];
   int   lat;
   int   fc_before;
   int   bad;

   initial begin
      // Identity S: keystream bytes 02,05,07,0D,0D,17
      tbl[0] = '{8'h41, 8'h43};
      tbl[1] = '{8'h00, 8'h05};
      tbl[2] = '{8'hFF, 8'hF8};
      tbl[3] = '{8'h0D, 8'h00};
      tbl[4] = '{8'h20, 8'h2D};
      tbl[5] = '{8'hA5, 8'hB2};

      reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0; load0 = 1'b0; load1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_addr", int'(s_addr0), 0);
      chk("rst_s_wdata", int'(s_wdata0), 0);
      chk("rst_s_wren", int'(s_wren0), 0);
      chk("rst_rom_addr", int'(rom_addr0), 0);
      chk("rst_ram_addr", int'(ram_addr0), 0);
      chk("rst_ram_wdata", int'(ram_wdata0), 0);
      chk("rst_ram_wren", int'(ram_wren0), 0);
      chk("rst_finished", int'(fin0), 0);
      reset_n = 1'b1;

      for (int x = 0; x < 256; x++) begin sinit[x] = 8'(x); rom[x] = 8'h00; end
      for (int v = 0; v < 6; v++) rom[v] = tbl[v].enc;
      load(0);
      run(0, 32, -1, -1, lat);
      for (int v = 0; v < 6; v++) chk($sformatf("ident_ram%0d", v), int'(ram0[v]), int'(tbl[v].plain));
      chk("ident_latency", lat, 2 + 13 * 32);
      chk("ident_finished_count", fcnt0, 1);
      chk("ij_swap_writes", int'({sw_a0, sw_d0, sw_a1, sw_d1}), 32'h01010101);
      chk("ij_s1_unchanged", int'(snap_s1), 1);
      chk("swap_s2", int'(snap_s2), 3);
      chk("swap_s3", int'(snap_s3), 2);

      for (int x = 0; x < 256; x++) rom[x] = 8'($urandom_range(0, 255));
      ksa();
      model(32);
      load(0);
      run(0, 32, 50, 200, lat);
      chk("gold_latency", lat, 418);
      compare0("gold");

      load(0);
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      repeat (98) @(negedge clk);
      fc_before = fcnt0;
      reset_n = 1'b0;
      #1;
      chk("abort_s_wren", int'(s_wren0), 0);
      chk("abort_ram_wren", int'(ram_wren0), 0);
      chk("abort_finished", int'(fin0), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("abort_no_done", fcnt0, fc_before);

      ksa();
      model(32);
      load(0);
      run(0, 32, -1, -1, lat);
      chk("rerun_latency", lat, 418);
      compare0("rerun");

      ksa();
      model(256);
      load(1);
      run(1, 256, -1, -1, lat);
      chk("len256_latency", lat, 2 + 13 * 256);
      bad = 0;
      for (int x = 0; x < 256; x++) if (ram1[x] !== expk[x] || wcnt1[x] != 1) bad++;
      chk("len256_ram_mismatches", bad, 0);
      bad = 0;
      for (int x = 0; x < 256; x++) if (smem1[x] !== ms[x]) bad++;
      chk("len256_s_mismatches", bad, 0);
      chk("len256_finished_count", fcnt1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prga_decrypt.md
Name: prga_decrypt

Overview:
- Second half of the RC4 core: the keystream/decrypt engine that consumes the S array after the key-schedule shuffle has finished.
- On start, runs the RC4 PRGA over MSG_LEN bytes.
- Per byte: reads and swaps S[i]/S[j] in the S working memory, reads the keystream byte, XORs it with the encrypted ROM byte, writes the plaintext to the decrypted-message RAM.
- Sits between the shuffle stage's finished strobe and the key-check/search controller.

Parameters:
- MSG_LEN, 32, number of message bytes to decrypt (1..2**MSG_AW).
- MSG_AW, 5, address width of the encrypted ROM and decrypted RAM.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- s_addr  output  8  S memory address
- s_wdata  output  8  S memory write data
- s_wren  output  1  S memory write enable
- s_rdata  input  8  S memory read data (synchronous RAM, 1-cycle read latency)
- rom_addr  output  MSG_AW  encrypted ROM address
- rom_rdata  input  8  encrypted byte (1-cycle read latency)
- ram_addr  output  MSG_AW  decrypted RAM address
- ram_wdata  output  8  plaintext byte
- ram_wren  output  1  decrypted RAM write enable
- finished  output  1  one-cycle done pulse

Behaviour:
- Reset (async, reset_n=0): state IDLE; i=j=k=0; si, sj, f, enc cleared.
- Reset outputs: s_addr=0, s_wdata=0, s_wren=0, rom_addr=0, ram_addr=0, ram_wdata=0, ram_wren=0, finished=0.
- All outputs are registered. Write enables are high only in their write states.
- States: IDLE, INIT, INC_I, WAIT_SI, LATCH_SI, ADDR_SJ, WAIT_SJ, LATCH_SJ, WR_SI, WR_SJ, ADDR_F, WAIT_F, LATCH_F, WR_RAM, NEXT, DONE.
- IDLE: start=1 -> INIT; otherwise stay.
- INIT: i=0, j=0, k=0 -> INC_I.
- INC_I: i=i+1 mod 256; s_addr=i+1.
- WAIT_SI: hold s_addr.
- LATCH_SI: si=s_rdata; j=j+s_rdata mod 256.
- ADDR_SJ: s_addr=j.
- WAIT_SJ: hold s_addr.
- LATCH_SJ: sj=s_rdata.
- WR_SI: s_addr=i, s_wdata=sj, s_wren=1.
- WR_SJ: s_addr=j, s_wdata=si, s_wren=1.
- ADDR_F: s_addr=(si+sj) mod 256; rom_addr=k.
- WAIT_F: hold s_addr and rom_addr.
- LATCH_F: f=s_rdata; enc=rom_rdata.
- WR_RAM: ram_addr=k, ram_wdata=f^enc, ram_wren=1.
- NEXT: if k==MSG_LEN-1 -> DONE; else k=k+1 -> INC_I.
- DONE: finished=1 for exactly one cycle -> IDLE.
- Latency: 13 cycles per byte. finished is high in cycle 2+13*MSG_LEN after the edge that samples start in IDLE.
- Arithmetic: i, j and si+sj are 8-bit and wrap mod 256 with no carry; k is MSG_AW bits.
- i==j: WR_SI then WR_SJ hit the same address; the last write (si) wins; values are equal, so S is unchanged.
- start while not IDLE: ignored; no restart, no queueing.
- start held high through DONE: a new run begins on the IDLE cycle after DONE.
- Reset mid-run: immediate abort to IDLE with enables low. Partial S/RAM contents stay in memory; no completion pulse.
- The S array is not re-initialised here; it must already hold the post-shuffle permutation.

Decomposition:
- Shared package rc4_pkg: state enum type, S_DEPTH=256, byte typedef, default MSG_LEN/MSG_AW constants (reused by the shuffle and search controller).
- No sub-module: one FSM with datapath registers in a single module. Memory instances live in the top level.

Test Plan:
- Identity S (S[x]=x), enc[0]=0x41, enc[1]=0x00 -> ram[0]=0x43 (i=j=1, f=S[2]=2); ram[1]=0x05 (i=2, j=3, f=S[5]=5); afterwards S[2]=3, S[3]=2.
- Golden model: S from KSA with secret_key 24'h000249, random 32-byte ROM -> all 32 RAM bytes and the final S match a software RC4 model. finished pulses once, at cycle 2+13*32=418.
- i==j case (identity S, byte 0): both writes target address 1 with value 0x01 -> S unchanged at index 1; ram correct.
- start pulses at cycles 50 and 200 during a run -> ignored. Exactly one finished; RAM writes at k=0..31 only, each once.
- reset_n low at cycle 100 -> all enables 0 and finished 0 immediately. Re-start after release -> full correct decrypt from k=0.
- MSG_LEN=256, MSG_AW=8 -> i wraps 255->0 on the 256th byte, result matches model, and finished pulses once.
